// File: rtl/btb_update_ctrl_pkg.sv
// Shared types for the BTB write-port sequencer: FSM states and the queued update entry.
package btb_update_ctrl_pkg;

  localparam int ADDR_BUS = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // One queued branch-resolution update, 66 bits: {pc, taken, target, error}.
  typedef struct packed {
    logic [ADDR_BUS-1:0] pc;
    logic                taken;
    logic [ADDR_BUS-1:0] target;
    logic                error;
  } upd_t;

  localparam int UPD_W = $bits(upd_t);

  function automatic upd_t mk_upd(input logic [ADDR_BUS-1:0] pc, input logic taken,
                                  input logic [ADDR_BUS-1:0] target, input logic error);
    upd_t u;
    u.pc     = pc;
    u.taken  = taken;
    u.target = target;
    u.error  = error;
    return u;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// DEPTH-entry update queue: two ordered writes (a before b) and one read per cycle, synchronous clear.
// Read data is the combinational head; the caller never reads empty or overfills.
module btb_upd_fifo
  import btb_update_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_a,
  input  upd_t          wr_a_dat,
  input  logic          wr_b,
  input  upd_t          wr_b_dat,
  input  logic          rd,
  output upd_t          rd_dat,
  output logic [CW-1:0] count
);

  upd_t          mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr_b;

  // The second write lands behind the first one when both fire together.
  assign wptr_b = wr_a ? wptr + PW'(1) : wptr;
  assign rd_dat = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_a && !clr) mem[wptr] <= wr_a_dat;
    if (wr_b && !clr) mem[wptr_b] <= wr_b_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(wr_a) + PW'(wr_b);
      if (rd) rptr <= rptr + PW'(1);
      count <= count + CW'(wr_a) + CW'(wr_b) - CW'(rd);
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Owns the BTB write port: round-robin queues ex/commit updates, drains one per cycle, sweeps all entries on flush.
// Accept-to-BTB-write is 2 cycles from empty; readies drop when the queue is full or a sweep runs.
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter  int BTBW  = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid_i,
  input  logic [ADDR_BUS-1:0] req0_pc_i,
  input  logic                req0_taken_i,
  input  logic [ADDR_BUS-1:0] req0_target_i,
  input  logic                req0_error_i,
  output logic                req0_ready_o,
  input  logic                req1_valid_i,
  input  logic [ADDR_BUS-1:0] req1_pc_i,
  input  logic                req1_taken_i,
  input  logic [ADDR_BUS-1:0] req1_target_i,
  input  logic                req1_error_i,
  output logic                req1_ready_o,
  input  logic                flush_i,
  output logic                btb_set_o,
  output logic [ADDR_BUS-1:0] btb_set_pc_o,
  output logic                btb_set_taken_o,
  output logic [ADDR_BUS-1:0] btb_set_target_o,
  output logic                btb_branch_is_error_o,
  output logic                busy_o,
  output logic [CW-1:0]       fifo_count_o
);

  state_t              state;
  logic                prio;
  logic [BTBW-1:0]     idx;
  logic [CW-1:0]       count;
  logic [CW-1:0]       free;
  upd_t                head;
  upd_t                upd0;
  upd_t                upd1;
  upd_t                wr_a_dat;
  upd_t                wr_b_dat;
  logic                can_accept;
  logic                acc0;
  logic                acc1;
  logic                wr_a;
  logic                wr_b;
  logic                pop;
  logic                prio_won;
  logic [ADDR_BUS-1:0] sweep_pc;

  // Readies are held low while reset is asserted so every output reads 0 then.
  assign can_accept = rst && (state == ST_IDLE) && !flush_i;
  assign free       = CW'(DEPTH) - count;

  // With one slot left only one request may enter; the prio holder wins a tie.
  assign req0_ready_o = can_accept &&
                        (free > CW'(1) || (free == CW'(1) && (!prio || !req1_valid_i)));
  assign req1_ready_o = can_accept &&
                        (free > CW'(1) || (free == CW'(1) && (prio || !req0_valid_i)));

  assign acc0 = req0_valid_i && req0_ready_o;
  assign acc1 = req1_valid_i && req1_ready_o;

  assign upd0 = mk_upd(req0_pc_i, req0_taken_i, req0_target_i, req0_error_i);
  assign upd1 = mk_upd(req1_pc_i, req1_taken_i, req1_target_i, req1_error_i);

  // Write port a always carries the prio holder so it lands ahead in the queue.
  assign wr_a     = prio ? acc1 : acc0;
  assign wr_b     = prio ? acc0 : acc1;
  assign wr_a_dat = prio ? upd1 : upd0;
  assign wr_b_dat = prio ? upd0 : upd1;
  assign prio_won = req0_valid_i && req1_valid_i && wr_a;

  assign pop      = (state == ST_IDLE) && !flush_i && (count != '0);
  assign sweep_pc = {{(ADDR_BUS - 2 - BTBW){1'b0}}, idx, 2'b00};

  btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush_i),
    .wr_a     (wr_a),
    .wr_a_dat (wr_a_dat),
    .wr_b     (wr_b),
    .wr_b_dat (wr_b_dat),
    .rd       (pop),
    .rd_dat   (head),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= ST_IDLE;
      prio                  <= 1'b0;
      idx                   <= '0;
      btb_set_o             <= 1'b0;
      btb_set_pc_o          <= '0;
      btb_set_taken_o       <= 1'b0;
      btb_set_target_o      <= '0;
      btb_branch_is_error_o <= 1'b0;
    end else begin
      if (prio_won) prio <= ~prio;
      btb_set_o <= 1'b0;
      if (state == ST_SWEEP) begin
        // Every entry is forced to strongly-not-taken; the BTB keys that on error=1, taken=0.
        btb_set_o             <= 1'b1;
        btb_set_pc_o          <= sweep_pc;
        btb_set_taken_o       <= 1'b0;
        btb_set_target_o      <= '0;
        btb_branch_is_error_o <= 1'b1;
        idx                   <= idx + BTBW'(1);
        if (&idx) state <= ST_IDLE;
      end else if (pop) begin
        btb_set_o             <= 1'b1;
        btb_set_pc_o          <= head.pc;
        btb_set_taken_o       <= head.taken;
        btb_set_target_o      <= head.target;
        btb_branch_is_error_o <= head.error;
      end
      // A flush mid-sweep still issues the current index, then restarts from 0.
      if (flush_i) begin
        state <= ST_SWEEP;
        idx   <= '0;
      end
    end
  end

  assign busy_o       = (state == ST_SWEEP);
  assign fifo_count_o = count;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized bench for btb_update_ctrl against a queue-based reference model.
module tb_btb_update_ctrl;

  localparam int BTBW   = 3;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int NSWEEP = 1 << BTBW;

  typedef struct packed {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tg;
    logic        er;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0, tk0 = 1'b0, tk1 = 1'b0, er0 = 1'b0, er1 = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   pc0 = '0, pc1 = '0, tg0 = '0, tg1 = '0;
  logic          rdy0, rdy1, set, stk, ser, busy;
  logic [31:0]   spc, stg;
  logic [CW-1:0] cnt;

  btb_update_ctrl #(.BTBW(BTBW), .DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req0_valid_i          (v0),
    .req0_pc_i             (pc0),
    .req0_taken_i          (tk0),
    .req0_target_i         (tg0),
    .req0_error_i          (er0),
    .req0_ready_o          (rdy0),
    .req1_valid_i          (v1),
    .req1_pc_i             (pc1),
    .req1_taken_i          (tk1),
    .req1_target_i         (tg1),
    .req1_error_i          (er1),
    .req1_ready_o          (rdy1),
    .flush_i               (flush),
    .btb_set_o             (set),
    .btb_set_pc_o          (spc),
    .btb_set_taken_o       (stk),
    .btb_set_target_o      (stg),
    .btb_branch_is_error_o (ser),
    .busy_o                (busy),
    .fifo_count_o          (cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   obs_sets = 0;
  int   obs_busy = 0;
  ent_t q[$];
  int   m_prio = 0;
  int   m_sweep = 0;
  int   m_idx = 0;
  ent_t e_out = '0;
  bit   e_set = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prio  = 0;
    m_sweep = 0;
    m_idx   = 0;
    e_out   = '0;
    e_set   = 1'b0;
  endtask

  task automatic drive(input bit a0, input bit a1, input bit fl);
    v0    = a0;
    v1    = a1;
    flush = fl;
    pc0   = $urandom;
    pc1   = $urandom;
    tg0   = $urandom;
    tg1   = $urandom;
    tk0   = $urandom_range(0, 1);
    tk1   = $urandom_range(0, 1);
    er0   = $urandom_range(0, 1);
    er1   = $urandom_range(0, 1);
  endtask

  // One clock: check readies at negedge, advance the model across the edge, check outputs after it.
  task automatic run_cycle();
    int   free;
    bit   r0, r1, a0, a1;
    ent_t n0, n1;
    @(negedge clk);
    free = DEPTH - q.size();
    r0 = !m_sweep && !flush && (free >= 2 || (free == 1 && (m_prio == 0 || !v1)));
    r1 = !m_sweep && !flush && (free >= 2 || (free == 1 && (m_prio == 1 || !v0)));
    check("rdy0", rdy0, r0);
    check("rdy1", rdy1, r1);
    a0 = v0 && r0;
    a1 = v1 && r1;
    n0 = '{pc: pc0, tk: tk0, tg: tg0, er: er0};
    n1 = '{pc: pc1, tk: tk1, tg: tg1, er: er1};

    e_set = 1'b0;
    if (m_sweep != 0) begin
      e_set    = 1'b1;
      e_out.pc = 32'(m_idx * 4);
      e_out.tk = 1'b0;
      e_out.tg = '0;
      e_out.er = 1'b1;
    end else if (!flush && q.size() > 0) begin
      e_set = 1'b1;
      e_out = q.pop_front();
    end
    if (flush) begin
      q.delete();
      m_sweep = 1;
      m_idx   = 0;
    end else if (m_sweep != 0) begin
      m_idx++;
      if (m_idx == NSWEEP) begin
        m_sweep = 0;
        m_idx   = 0;
      end
    end
    if (m_prio == 0) begin
      if (a0) q.push_back(n0);
      if (a1) q.push_back(n1);
    end else begin
      if (a1) q.push_back(n1);
      if (a0) q.push_back(n0);
    end
    if (v0 && v1 && (m_prio == 1 ? a1 : a0)) m_prio = 1 - m_prio;

    @(posedge clk);
    #1;
    check("set", set, e_set);
    check("pc", spc, e_out.pc);
    check("taken", stk, e_out.tk);
    check("target", stg, e_out.tg);
    check("error", ser, e_out.er);
    check("busy", busy, m_sweep != 0);
    check("count", cnt, q.size());
    if (set && ser) obs_sets++;
    if (busy) obs_busy++;
  endtask

  // Called just after a posedge: reset drops between edges and outputs must clear at once.
  task automatic async_reset();
    drive(0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("arst_set", set, 0);
    check("arst_pc", spc, 0);
    check("arst_taken", stk, 0);
    check("arst_target", stg, 0);
    check("arst_error", ser, 0);
    check("arst_busy", busy, 0);
    check("arst_count", cnt, 0);
    check("arst_rdy0", rdy0, 0);
    check("arst_rdy1", rdy1, 0);
    @(posedge clk);
    #1;
    check("arst_hold_set", set, 0);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #7;
    check("rst_set", set, 0);
    check("rst_pc", spc, 0);
    check("rst_target", stg, 0);
    check("rst_error", ser, 0);
    check("rst_busy", busy, 0);
    check("rst_count", cnt, 0);
    check("rst_rdy0", rdy0, 0);
    check("rst_rdy1", rdy1, 0);
    rst = 1'b1;

    drive(0, 0, 0);
    run_cycle();
    check("idle_rdy0", rdy0, 1);
    check("idle_rdy1", rdy1, 1);

    // Single req0 update reaches the BTB two edges after it is presented.
    drive(1, 0, 0);
    pc0 = 32'h100;
    tk0 = 1'b1;
    tg0 = 32'h200;
    er0 = 1'b0;
    run_cycle();
    check("single_early_set", set, 0);
    check("single_cnt", cnt, 1);
    drive(0, 0, 0);
    run_cycle();
    check("single_set", set, 1);
    check("single_pc", spc, 32'h100);
    check("single_taken", stk, 1);
    check("single_target", stg, 32'h200);
    drive(0, 0, 0);
    run_cycle();
    check("single_one_pulse", set, 0);

    // Both requesters every cycle: queue settles at DEPTH-1 with alternating grants.
    repeat (30) begin
      drive(1, 1, 0);
      run_cycle();
      check("cnt_le_depth", cnt <= DEPTH, 1);
    end
    check("pre_flush_cnt", cnt, 3);

    // Flush with a non-empty queue: queue discarded, full sweep follows.
    obs_sets = 0;
    obs_busy = 0;
    drive(1, 1, 1);
    run_cycle();
    check("flush_cnt", cnt, 0);
    repeat (NSWEEP) begin
      drive(1, 1, 0);
      run_cycle();
    end
    check("sweep_writes", obs_sets, NSWEEP);
    check("sweep_busy_cycles", obs_busy, NSWEEP);
    check("sweep_done_busy", busy, 0);

    // Restart the sweep when idx 5 is about to issue.
    drive(0, 0, 1);
    run_cycle();
    obs_sets = 0;
    for (int g = 0; g < 20 && m_idx != 5; g++) begin
      drive(0, 0, 0);
      run_cycle();
    end
    check("idx5_busy", busy, 1);
    drive(0, 0, 1);
    run_cycle();
    drive(0, 0, 0);
    run_cycle();
    check("restart_set", set, 1);
    check("restart_pc", spc, 0);
    repeat (NSWEEP) begin
      drive(0, 0, 0);
      run_cycle();
    end
    check("restart_total", obs_sets, 6 + NSWEEP);

    // Random traffic with occasional flushes.
    repeat (400) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      run_cycle();
    end

    // Asynchronous reset mid-sweep, then mid-drain.
    drive(0, 0, 1);
    run_cycle();
    repeat (3) begin
      drive(0, 0, 0);
      run_cycle();
    end
    check("mid_sweep_busy", busy, 1);
    async_reset();
    drive(0, 0, 0);
    run_cycle();
    repeat (3) begin
      drive(1, 1, 0);
      run_cycle();
    end
    check("mid_drain_cnt_nz", cnt != 0, 1);
    async_reset();
    repeat (20) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 0);
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
